// File: rtl/pwm_symbol_sequencer.sv
// pwm_symbol_sequencer
// Buffers frame bytes, prepends an alternating preamble and serialises each
// bit (MSB first) as an OOK duty level held for a programmable symbol period.
// Optional build macro: MANCHESTER_EN (each symbol becomes two half-symbols).
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   cfg_enable            allow frames to start/continue
//   cfg_sym_period        cycles per symbol (0 behaves as 1)
//   cfg_level1/0, cfg_idle duty levels for '1', '0' and idle
//   s_valid/s_ready/s_data/s_last  byte input stream
//   pwm_threshold         registered duty to the PWM counter
//   sym_strobe            pulse on the first cycle of each symbol
//   busy                  high whenever not idle
//   underrun              sticky: FIFO ran dry mid-frame
`timescale 1ns/1ps
module pwm_symbol_sequencer #(
  parameter int unsigned DUTY_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PREAMBLE_N = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cfg_enable,
  input  logic [15:0]       cfg_sym_period,
  input  logic [DUTY_W-1:0] cfg_level1,
  input  logic [DUTY_W-1:0] cfg_level0,
  input  logic [DUTY_W-1:0] cfg_idle,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic [DUTY_W-1:0] pwm_threshold,
  output logic              sym_strobe,
  output logic              busy,
  output logic              underrun
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PRE_W = $clog2(PREAMBLE_N);
  localparam int unsigned PER_W = 16;
`ifdef MANCHESTER_EN
  localparam bit MANCH_EN = 1'b1;
`else
  localparam bit MANCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA} state_t;

  // Byte FIFO: {last, data}
  logic [8:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_d;
  logic             push_c, pop_c, fifo_empty_c;
  logic [8:0]       fifo_rd_c;

  state_t            state_q, state_d;
  logic [PER_W-1:0]  sym_cnt_q, sym_cnt_d, per_q, per_d, per_m1_c;
  logic [PRE_W-1:0]  pre_idx_q, pre_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        bits_q, bits_d;
  logic              last_q, last_d, bit_q, bit_d, half_q, half_d;
  logic [DUTY_W-1:0] lvl1_q, lvl1_d, lvl0_q, lvl0_d, thr_d;
  logic              strobe_d, underrun_d, start_sym_c, sym_val_c;

  assign push_c       = s_valid & s_ready;
  assign fifo_empty_c = (fifo_cnt == CNT_W'(0));
  assign fifo_rd_c    = fifo_mem[rd_ptr];
  assign fifo_cnt_d   = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
  assign per_m1_c     = (cfg_sym_period == PER_W'(0)) ? PER_W'(0) : cfg_sym_period - PER_W'(1);

  // FIFO storage; contents are invalidated by pointer reset only
  always_ff @(posedge aclk) begin
    if (push_c) fifo_mem[wr_ptr] <= {s_last, s_data};
  end

  // Next-state, symbol sequencing and output decisions
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    per_d       = per_q;
    pre_idx_d   = pre_idx_q;
    shreg_d     = shreg_q;
    bits_d      = bits_q;
    last_d      = last_q;
    bit_d       = bit_q;
    half_d      = half_q;
    lvl1_d      = lvl1_q;
    lvl0_d      = lvl0_q;
    thr_d       = pwm_threshold;
    strobe_d    = 1'b0;
    underrun_d  = underrun;
    pop_c       = 1'b0;
    start_sym_c = 1'b0;
    sym_val_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        thr_d = cfg_idle;
        if (cfg_enable && !fifo_empty_c) begin
          state_d     = ST_PREAMBLE;
          underrun_d  = 1'b0;
          pre_idx_d   = PRE_W'(0);
          start_sym_c = 1'b1;
          sym_val_c   = 1'b1;
        end
      end
      default: begin
        if (sym_cnt_q != per_q) begin
          sym_cnt_d = sym_cnt_q + PER_W'(1);
        end else if (MANCH_EN && !half_q) begin
          // second half carries the complementary level
          half_d    = 1'b1;
          sym_cnt_d = PER_W'(0);
          thr_d     = bit_q ? lvl0_q : lvl1_q;
        end else if (!cfg_enable) begin
          state_d = ST_IDLE;
          thr_d   = cfg_idle;
        end else if (state_q == ST_PREAMBLE && pre_idx_q != PRE_W'(PREAMBLE_N - 1)) begin
          pre_idx_d   = pre_idx_q + PRE_W'(1);
          start_sym_c = 1'b1;
          sym_val_c   = pre_idx_q[0];
        end else if (state_q == ST_DATA && bits_q != 3'd0) begin
          bits_d      = bits_q - 3'd1;
          shreg_d     = {shreg_q[6:0], 1'b0};
          start_sym_c = 1'b1;
          sym_val_c   = shreg_q[6];
        end else if (state_q == ST_DATA && last_q) begin
          state_d = ST_IDLE;
          thr_d   = cfg_idle;
        end else if (fifo_empty_c) begin
          state_d    = ST_IDLE;
          thr_d      = cfg_idle;
          underrun_d = 1'b1;
        end else begin
          pop_c       = 1'b1;
          state_d     = ST_DATA;
          shreg_d     = fifo_rd_c[7:0];
          last_d      = fifo_rd_c[8];
          bits_d      = 3'd7;
          start_sym_c = 1'b1;
          sym_val_c   = fifo_rd_c[7];
        end
      end
    endcase
    // Levels and period are captured at every symbol start
    if (start_sym_c) begin
      sym_cnt_d = PER_W'(0);
      half_d    = 1'b0;
      bit_d     = sym_val_c;
      lvl1_d    = cfg_level1;
      lvl0_d    = cfg_level0;
      per_d     = per_m1_c;
      strobe_d  = 1'b1;
      thr_d     = sym_val_c ? cfg_level1 : cfg_level0;
    end
  end

  // State and datapath registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      wr_ptr        <= PTR_W'(0);
      rd_ptr        <= PTR_W'(0);
      fifo_cnt      <= CNT_W'(0);
      s_ready       <= 1'b0;
      sym_cnt_q     <= PER_W'(0);
      per_q         <= PER_W'(0);
      pre_idx_q     <= PRE_W'(0);
      shreg_q       <= 8'd0;
      bits_q        <= 3'd0;
      last_q        <= 1'b0;
      bit_q         <= 1'b0;
      half_q        <= 1'b0;
      lvl1_q        <= DUTY_W'(0);
      lvl0_q        <= DUTY_W'(0);
      pwm_threshold <= DUTY_W'(0);
      sym_strobe    <= 1'b0;
      busy          <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt      <= fifo_cnt_d;
      s_ready       <= (fifo_cnt_d != CNT_W'(FIFO_DEPTH));
      sym_cnt_q     <= sym_cnt_d;
      per_q         <= per_d;
      pre_idx_q     <= pre_idx_d;
      shreg_q       <= shreg_d;
      bits_q        <= bits_d;
      last_q        <= last_d;
      bit_q         <= bit_d;
      half_q        <= half_d;
      lvl1_q        <= lvl1_d;
      lvl0_q        <= lvl0_d;
      pwm_threshold <= thr_d;
      sym_strobe    <= strobe_d;
      busy          <= (state_d != ST_IDLE);
      underrun      <= underrun_d;
    end
  end

endmodule
